// File: rtl/parity_pkg.sv
// Shared types for the parity frame serializer and its downstream checker.
package parity_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY
  } state_t;

  localparam int PARITY_EVEN     = 0;
  localparam int PARITY_ODD_MODE = 1;

endpackage

// File: rtl/parity_frame_serializer.sv
// LSB-first word serializer with an appended parity bit; first bit appears the cycle after accept.
// data_ready is low while data bits are shifting, so upstream holds its word; frames run back-to-back.
module parity_frame_serializer
  import parity_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int PARITY_ODD = PARITY_EVEN
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             x,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             frame_end
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic          PAR_INV  = (PARITY_ODD != 0);

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic             r_parity;
  logic             r_x;
  logic             r_bit_valid;
  logic             r_frame_start;
  logic             r_frame_end;
  logic             w_accept;

  assign data_ready  = (r_state != DATA);
  assign w_accept    = data_valid && data_ready;
  assign x           = r_x;
  assign bit_valid   = r_bit_valid;
  assign frame_start = r_frame_start;
  assign frame_end   = r_frame_end;

  // r_shift holds the bits not yet driven onto x; bit 0 goes out on the accept edge itself.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_shift       <= '0;
      r_cnt         <= '0;
      r_parity      <= 1'b0;
      r_x           <= 1'b0;
      r_bit_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
    end else begin
      r_frame_start <= 1'b0;
      r_frame_end   <= 1'b0;
      case (r_state)
        DATA: begin
          if (r_cnt == LAST_BIT) begin
            r_state     <= PARITY;
            r_x         <= r_parity;
            r_frame_end <= 1'b1;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_x     <= r_shift[0];
            r_shift <= r_shift >> 1;
          end
        end
        default: begin
          if (w_accept) begin
            r_state       <= DATA;
            r_shift       <= data_in >> 1;
            r_x           <= data_in[0];
            r_cnt         <= '0;
            r_parity      <= (^data_in) ^ PAR_INV;
            r_bit_valid   <= 1'b1;
            r_frame_start <= 1'b1;
          end else begin
            r_state     <= IDLE;
            r_x         <= 1'b0;
            r_bit_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_serializer.sv
// Directed bench: even-mode and odd-mode serializers, frames checked bit by bit against hand-computed vectors.
module tb_parity_frame_serializer;
  import parity_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       data_valid = 1'b0;
  logic       data_ready, x, bit_valid, frame_start, frame_end;

  logic [7:0] od_data_in = 8'h00;
  logic       od_data_valid = 1'b0;
  logic       od_data_ready, od_x, od_bit_valid, od_frame_start, od_frame_end;

  int   n_cmp = 0;
  int   n_err = 0;
  logic chk_par;

  always #5 clock = ~clock;

  parity_frame_serializer #(.WIDTH(8), .PARITY_ODD(PARITY_EVEN)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .data_valid(data_valid),
    .data_ready(data_ready), .x(x), .bit_valid(bit_valid),
    .frame_start(frame_start), .frame_end(frame_end)
  );

  parity_frame_serializer #(.WIDTH(8), .PARITY_ODD(PARITY_ODD_MODE)) dut_odd (
    .clock(clock), .reset(reset), .data_in(od_data_in), .data_valid(od_data_valid),
    .data_ready(od_data_ready), .x(od_x), .bit_valid(od_bit_valid),
    .frame_start(od_frame_start), .frame_end(od_frame_end)
  );

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_cmp++; if (x !== 1'b0) begin n_err++; $display("FAIL reset_x: got %b want 0", x); end
    n_cmp++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL reset_bit_valid: got %b want 0", bit_valid); end
    n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL reset_frame_start: got %b want 0", frame_start); end
    n_cmp++; if (frame_end !== 1'b0) begin n_err++; $display("FAIL reset_frame_end: got %b want 0", frame_end); end
    n_cmp++; if (data_ready !== 1'b1) begin n_err++; $display("FAIL reset_data_ready: got %b want 1", data_ready); end
    n_cmp++; if (od_data_ready !== 1'b1) begin n_err++; $display("FAIL reset_odd_data_ready: got %b want 1", od_data_ready); end
    reset = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL idle_bit_valid: got %b want 0", bit_valid); end
  endtask

  task automatic test_single_frames();
    logic [7:0] words [2];
    logic [8:0] exps  [2];
    logic [8:0] e;
    words[0] = 8'hB4; exps[0] = 9'h0B4;
    words[1] = 8'h07; exps[1] = 9'h107;
    for (int f = 0; f < 2; f++) begin
      e = exps[f];
      chk_par = 1'b0;
      @(negedge clock);
      data_in = words[f]; data_valid = 1'b1;
      @(posedge clock);
      #1 data_valid = 1'b0; data_in = ~words[f];
      for (int i = 0; i < 9; i++) begin
        @(negedge clock);
        if (bit_valid) chk_par = chk_par ^ x;
        n_cmp++; if (x !== e[i]) begin n_err++; $display("FAIL single%0d_x[%0d]: got %b want %b", f, i, x, e[i]); end
        n_cmp++; if (bit_valid !== 1'b1) begin n_err++; $display("FAIL single%0d_bit_valid[%0d]: got %b want 1", f, i, bit_valid); end
        n_cmp++; if (frame_start !== (i == 0)) begin n_err++; $display("FAIL single%0d_frame_start[%0d]: got %b want %b", f, i, frame_start, (i == 0)); end
        n_cmp++; if (frame_end !== (i == 8)) begin n_err++; $display("FAIL single%0d_frame_end[%0d]: got %b want %b", f, i, frame_end, (i == 8)); end
        n_cmp++; if (data_ready !== (i == 8)) begin n_err++; $display("FAIL single%0d_data_ready[%0d]: got %b want %b", f, i, data_ready, (i == 8)); end
      end
      n_cmp++; if (chk_par !== 1'b0) begin n_err++; $display("FAIL single%0d_checker_even_odd: got %b want 0", f, chk_par); end
      @(negedge clock);
      n_cmp++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL single%0d_after_bit_valid: got %b want 0", f, bit_valid); end
      n_cmp++; if (data_ready !== 1'b1) begin n_err++; $display("FAIL single%0d_after_data_ready: got %b want 1", f, data_ready); end
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] e;
    e = {9'h107, 9'h0B4};
    chk_par = 1'b0;
    @(negedge clock);
    data_in = 8'hB4; data_valid = 1'b1;
    @(posedge clock);
    #1 data_in = 8'h07;
    for (int i = 0; i < 18; i++) begin
      @(negedge clock);
      if (bit_valid) chk_par = chk_par ^ x;
      n_cmp++; if (bit_valid !== 1'b1) begin n_err++; $display("FAIL b2b_bit_valid[%0d]: got %b want 1", i, bit_valid); end
      n_cmp++; if (x !== e[i]) begin n_err++; $display("FAIL b2b_x[%0d]: got %b want %b", i, x, e[i]); end
      n_cmp++; if (frame_start !== (i == 0 || i == 9)) begin n_err++; $display("FAIL b2b_frame_start[%0d]: got %b want %b", i, frame_start, (i == 0 || i == 9)); end
      n_cmp++; if (frame_end !== (i == 8 || i == 17)) begin n_err++; $display("FAIL b2b_frame_end[%0d]: got %b want %b", i, frame_end, (i == 8 || i == 17)); end
      if (i == 9) data_valid = 1'b0;
    end
    n_cmp++; if (chk_par !== 1'b0) begin n_err++; $display("FAIL b2b_checker_even_odd: got %b want 0", chk_par); end
    @(negedge clock);
    n_cmp++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL b2b_after_bit_valid: got %b want 0", bit_valid); end
  endtask

  task automatic test_odd_parity();
    logic [7:0] words [2];
    logic [8:0] exps  [2];
    logic [8:0] e;
    words[0] = 8'h00; exps[0] = 9'h100;
    words[1] = 8'hFF; exps[1] = 9'h1FF;
    for (int f = 0; f < 2; f++) begin
      e = exps[f];
      @(negedge clock);
      od_data_in = words[f]; od_data_valid = 1'b1;
      @(posedge clock);
      #1 od_data_valid = 1'b0; od_data_in = ~words[f];
      for (int i = 0; i < 9; i++) begin
        @(negedge clock);
        n_cmp++; if (od_x !== e[i]) begin n_err++; $display("FAIL odd%0d_x[%0d]: got %b want %b", f, i, od_x, e[i]); end
        n_cmp++; if (od_bit_valid !== 1'b1) begin n_err++; $display("FAIL odd%0d_bit_valid[%0d]: got %b want 1", f, i, od_bit_valid); end
        n_cmp++; if (od_frame_end !== (i == 8)) begin n_err++; $display("FAIL odd%0d_frame_end[%0d]: got %b want %b", f, i, od_frame_end, (i == 8)); end
      end
      @(negedge clock);
      n_cmp++; if (od_bit_valid !== 1'b0) begin n_err++; $display("FAIL odd%0d_after_bit_valid: got %b want 0", f, od_bit_valid); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [8:0] e;
    e = 9'h101;
    @(negedge clock);
    data_in = 8'hFF; data_valid = 1'b1;
    @(posedge clock);
    #1 data_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_cmp++; if (x !== 1'b1) begin n_err++; $display("FAIL abort_pre_x[%0d]: got %b want 1", i, x); end
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (x !== 1'b0) begin n_err++; $display("FAIL abort_x: got %b want 0", x); end
    n_cmp++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL abort_bit_valid: got %b want 0", bit_valid); end
    n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL abort_frame_start: got %b want 0", frame_start); end
    n_cmp++; if (frame_end !== 1'b0) begin n_err++; $display("FAIL abort_frame_end: got %b want 0", frame_end); end
    n_cmp++; if (data_ready !== 1'b1) begin n_err++; $display("FAIL abort_data_ready: got %b want 1", data_ready); end
    @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    n_cmp++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL abort_no_resume: got %b want 0", bit_valid); end
    data_in = 8'h01; data_valid = 1'b1;
    @(posedge clock);
    #1 data_valid = 1'b0; data_in = 8'h00;
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      n_cmp++; if (x !== e[i]) begin n_err++; $display("FAIL abort_new_x[%0d]: got %b want %b", i, x, e[i]); end
      n_cmp++; if (bit_valid !== 1'b1) begin n_err++; $display("FAIL abort_new_bit_valid[%0d]: got %b want 1", i, bit_valid); end
      n_cmp++; if (frame_start !== (i == 0)) begin n_err++; $display("FAIL abort_new_frame_start[%0d]: got %b want %b", i, frame_start, (i == 0)); end
      n_cmp++; if (frame_end !== (i == 8)) begin n_err++; $display("FAIL abort_new_frame_end[%0d]: got %b want %b", i, frame_end, (i == 8)); end
    end
  endtask

  task automatic test_data_in_ignored();
    logic [8:0] e;
    e = 9'h0B4;
    @(negedge clock);
    data_in = 8'hB4; data_valid = 1'b1;
    @(posedge clock);
    #1 data_valid = 1'b0; data_in = 8'h5A;
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      n_cmp++; if (x !== e[i]) begin n_err++; $display("FAIL ignore_x[%0d]: got %b want %b", i, x, e[i]); end
      n_cmp++; if (frame_start !== (i == 0)) begin n_err++; $display("FAIL ignore_frame_start[%0d]: got %b want %b", i, frame_start, (i == 0)); end
      n_cmp++; if (frame_end !== (i == 8)) begin n_err++; $display("FAIL ignore_frame_end[%0d]: got %b want %b", i, frame_end, (i == 8)); end
      if (i == 2) begin data_in = 8'hFF; data_valid = 1'b1; end
      if (i == 4) begin data_in = 8'h00; data_valid = 1'b0; end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_cmp++; if (bit_valid !== 1'b0) begin n_err++; $display("FAIL ignore_extra_frame[%0d]: got %b want 0", i, bit_valid); end
    end
  endtask

  initial begin
    test_reset();
    test_single_frames();
    test_back_to_back();
    test_odd_parity();
    test_reset_mid_frame();
    test_data_in_ignored();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/parity_frame_serializer.md
Name: parity_frame_serializer

Overview:
Upstream feeder for the serial parity checker. Accepts a parallel word over a valid/ready handshake and shifts it out LSB-first, one bit per clock, on the serial line x. It then appends one parity bit. In even mode, every complete frame carries an even number of ones, so the downstream checker's running parity returns to "even" at each frame boundary.

Parameters:
WIDTH, 8, data word width in bits (>= 2)
PARITY_ODD, 0, 0 = even parity bit appended; 1 = odd parity bit appended

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
data_in  input  WIDTH  parallel word to transmit
data_valid  input  1  data_in holds a word to send
data_ready  output  1  block can accept a word this cycle
x  output  1  serial bit to parity checker
bit_valid  output  1  x carries a frame bit this cycle
frame_start  output  1  high with the first data bit of a frame
frame_end  output  1  high with the parity bit (last bit of a frame)

Behaviour:
- Reset (asynchronous, immediate, independent of clock):
  - state = IDLE; x = 0; bit_valid = 0; frame_start = 0; frame_end = 0.
  - data_ready = 1; bit counter = 0; shift register = 0.
- All outputs are registered except data_ready, which is decoded from state: high in IDLE or PARITY, low in DATA.
- Accept: data_valid && data_ready at a rising edge.
  - Latches data_in into the shift register.
  - Computes parity = (^data_in) ^ PARITY_ODD.
  - data_in is ignored at all other times; later changes to it do not affect the frame in flight.
- States:
  - IDLE: x = 0, bit_valid = 0. On accept -> DATA.
  - DATA: x = shift[0], bit_valid = 1. frame_start = 1 only on bit index 0. Shift right each cycle; counter increments. Counter at WIDTH-1 -> PARITY.
  - PARITY: x = parity, bit_valid = 1, frame_end = 1. On accept in this cycle -> DATA (new frame starts the very next cycle); otherwise -> IDLE.
- Latency: accept edge -> first bit on x the following cycle. A frame is WIDTH+1 consecutive cycles.
- Throughput: with data_valid held high, frames are back-to-back with no idle gap (WIDTH+1 cycles per word).
- data_valid during DATA: no accept; data_ready = 0; the upstream source must hold its word.
- Counter width: $clog2(WIDTH). Wrap is not used; the counter is cleared on entry to DATA.
- Reset mid-frame: the frame is aborted and never resumed. The next accept after reset release starts a fresh frame at bit 0.

Decomposition:
- Shared package parity_pkg holds:
  - state enum {IDLE, DATA, PARITY};
  - localparam PARITY_EVEN = 0, PARITY_ODD_MODE = 1 (shared with the checker bench).
- No sub-module is needed. Parity is a single reduction-XOR inline, and the shifter, counter and FSM live in this one module.

Test Plan:
- WIDTH=8, even. Send 0xB4 -> x over 9 cycles = 0,0,1,0,1,1,0,1,0. frame_start only on cycle 1, frame_end only on cycle 9. Downstream checker even_odd = 0 after cycle 9.
- Send 0x07 -> x = 1,1,1,0,0,0,0,0,1 (parity 1). data_ready = 0 for cycles 1-8 and = 1 on cycle 9.
- data_valid held high with 0xB4 then 0x07 -> 18 consecutive bit_valid cycles, no gap. Second frame_start falls exactly one cycle after the first frame_end.
- PARITY_ODD=1, send 0x00 -> 8 zeros then parity bit 1. Send 0xFF -> 8 ones then parity bit 1.
- Assert reset asynchronously after 3 data bits of 0xFF (between clock edges). Outputs x, bit_valid, frame_start and frame_end drop to 0 immediately, and data_ready = 1. After release, sending 0x01 produces the full 9-bit frame 1,0,0,0,0,0,0,0,1.
- Toggle data_in and pulse data_valid during DATA -> the transmitted frame is unchanged and no extra frame is produced.
